// File: rtl/pipe_trace_pkg.sv
// Shared constants and entry-layout helpers for the pipeline trace buffer.
package pipe_trace_pkg;

    // Capture FSM encoding; also visible on the state output.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Traced pipeline stage indices.
    localparam int unsigned STAGE_FETCH = 0;
    localparam int unsigned STAGE_IF_OF = 1;
    localparam int unsigned STAGE_OF_EX = 2;
    localparam int unsigned STAGE_EX_MA = 3;
    localparam int unsigned STAGE_MA_WB = 4;

    // Entry layout, LSB first: wb_data, wb_addr, wb_we, stage PCs (stage 0 lowest), cycle.
    function automatic int unsigned wb_addr_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned wb_we_bit(input int unsigned reg_aw,
                                              input int unsigned data_w);
        return data_w + reg_aw;
    endfunction

    function automatic int unsigned stage_pc_lsb(input int unsigned stage,
                                                 input int unsigned addr_w,
                                                 input int unsigned reg_aw,
                                                 input int unsigned data_w);
        return data_w + reg_aw + 1 + stage * addr_w;
    endfunction

    function automatic int unsigned cycle_lsb(input int unsigned num_stages,
                                              input int unsigned addr_w,
                                              input int unsigned reg_aw,
                                              input int unsigned data_w);
        return data_w + reg_aw + 1 + num_stages * addr_w;
    endfunction

    function automatic int unsigned entry_width(input int unsigned cyc_w,
                                                input int unsigned num_stages,
                                                input int unsigned addr_w,
                                                input int unsigned reg_aw,
                                                input int unsigned data_w);
        return cyc_w + num_stages * addr_w + 1 + reg_aw + data_w;
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// Simple dual-port trace storage: synchronous write, registered read.
// A read of the address being written in the same cycle returns the old contents.
module pipe_trace_buffer_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Trace capture for the 5-stage pipeline: circular buffer of per-stage PCs plus
// writeback tuple, frozen a programmable number of entries after a trigger.
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 4,
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CYC_W      = 16,
    // Derived widths; leave at their defaults.
    parameter int unsigned PTR_W      = $clog2(DEPTH),
    parameter int unsigned SEL_W      = $clog2(NUM_STAGES),
    parameter int unsigned ENTRY_W    = entry_width(CYC_W, NUM_STAGES, ADDR_W, REG_AW, DATA_W)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cap_en,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_pc,
    input  logic                         wb_we,
    input  logic [REG_AW-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         arm,
    input  logic                         trig_en,
    input  logic [ADDR_W-1:0]            trig_pc,
    input  logic [SEL_W-1:0]             trig_stage,
    input  logic                         force_trig,
    input  logic [PTR_W-1:0]             post_cnt,
    input  logic                         rd_en,
    input  logic [PTR_W-1:0]             rd_idx,
    output logic [ENTRY_W-1:0]           rd_data,
    output logic                         rd_valid,
    output logic [1:0]                   state,
    output logic                         done,
    output logic [PTR_W:0]               count,
    output logic                         wrapped,
    output logic [CYC_W-1:0]             trig_cycle
);

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   remaining_q, remaining_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               wrapped_q, wrapped_d;
    logic [CYC_W-1:0]   trig_cycle_q, trig_cycle_d;
    logic [CYC_W-1:0]   cyc_q;
    logic               rd_valid_q, rd_zero_q;

    logic [ADDR_W-1:0]  sel_pc;
    logic               stage_ok;
    logic               hit, capture;
    logic [PTR_W-1:0]   rd_addr;
    logic               rd_oob;
    logic [ENTRY_W-1:0] wr_entry, ram_rdata;

    // Select the compared stage PC; out-of-range stage selects never match.
    always_comb begin
        sel_pc   = '0;
        stage_ok = 1'b0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (trig_stage == SEL_W'(s)) begin
                sel_pc   = stage_pc[s*ADDR_W +: ADDR_W];
                stage_ok = 1'b1;
            end
        end
    end

    assign hit = (state_q == ST_ARMED) && cap_en &&
                 (force_trig || (trig_en && stage_ok && (sel_pc == trig_pc)));
    // arm takes precedence, so nothing is captured in the arm cycle.
    assign capture  = !arm && cap_en && ((state_q == ST_ARMED) || (state_q == ST_POST));
    assign wr_entry = {cyc_q, stage_pc, wb_we, wb_addr, wb_data};

    // Next-state logic for the capture FSM, pointers and trigger bookkeeping.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        remaining_d  = remaining_q;
        count_d      = count_q;
        wrapped_d    = wrapped_q;
        trig_cycle_d = trig_cycle_q;
        if (arm) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = '0;
            remaining_d = '0;
            count_d     = '0;
            wrapped_d   = 1'b0;
        end else begin
            if (capture) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q != (PTR_W+1)'(DEPTH)) begin
                    count_d = count_q + 1'b1;
                end
                if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
                    wrapped_d = 1'b1;
                end
            end
            case (state_q)
                ST_ARMED: begin
                    if (hit) begin
                        trig_cycle_d = cyc_q;
                        if (post_cnt == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            remaining_d = post_cnt;
                            state_d     = ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (capture) begin
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == PTR_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers and free-running cycle stamp.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            remaining_q  <= '0;
            count_q      <= '0;
            wrapped_q    <= 1'b0;
            trig_cycle_q <= '0;
            cyc_q        <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            remaining_q  <= remaining_d;
            count_q      <= count_d;
            wrapped_q    <= wrapped_d;
            trig_cycle_q <= trig_cycle_d;
            cyc_q        <= cyc_q + 1'b1;
        end
    end

    // Index 0 is the oldest entry: once wrapped, that is the slot about to be overwritten.
    assign rd_addr = (wrapped_q ? wr_ptr_q : '0) + rd_idx;
    assign rd_oob  = ({1'b0, rd_idx} >= count_q);

    // Readback handshake: valid one cycle after rd_en, zeroed for unfilled indices.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            rd_valid_q <= rd_en;
            rd_zero_q  <= rd_oob;
        end
    end

    pipe_trace_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign rd_data    = (rd_valid_q && !rd_zero_q) ? ram_rdata : '0;
    assign rd_valid   = rd_valid_q;
    assign state      = state_q;
    assign done       = (state_q == ST_DONE);
    assign count      = count_q;
    assign wrapped    = wrapped_q;
    assign trig_cycle = trig_cycle_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer with default parameters (DEPTH=16).
module tb_pipe_trace_buffer;

    localparam int ENTRY_W = 213;
    localparam int PC0_LSB = 37;   // FETCH PC field
    localparam int PC3_LSB = 133;  // EX/MA PC field
    localparam int CYC_LSB = 197;  // cycle stamp field

    logic               clk;
    logic               reset;
    logic               cap_en;
    logic [159:0]       stage_pc;
    logic               wb_we;
    logic [3:0]         wb_addr;
    logic [31:0]        wb_data;
    logic               arm;
    logic               trig_en;
    logic [31:0]        trig_pc;
    logic [2:0]         trig_stage;
    logic               force_trig;
    logic [3:0]         post_cnt;
    logic               rd_en;
    logic [3:0]         rd_idx;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_valid;
    logic [1:0]         state;
    logic               done;
    logic [4:0]         count;
    logic               wrapped;
    logic [15:0]        trig_cycle;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc_m  = 0;
    logic [15:0] stamp [0:19];
    logic [15:0] cyc5_obs;

    pipe_trace_buffer #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .REG_AW     (4),
        .NUM_STAGES (5),
        .DEPTH      (16),
        .CYC_W      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cap_en     (cap_en),
        .stage_pc   (stage_pc),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .arm        (arm),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .trig_stage (trig_stage),
        .force_trig (force_trig),
        .post_cnt   (post_cnt),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .state      (state),
        .done       (done),
        .count      (count),
        .wrapped    (wrapped),
        .trig_cycle (trig_cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; cyc_m tracks the expected cycle counter after the edge.
    task automatic step();
        @(posedge clk);
        if (reset) cyc_m = 0;
        else       cyc_m = cyc_m + 1;
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle read; rd_valid/rd_data are then visible.
    task automatic read_idx(input logic [3:0] idx);
        rd_en  = 1'b1;
        rd_idx = idx;
        step();
        rd_en  = 1'b0;
    endtask

    task automatic drive_wb(input int k);
        wb_we   = k[0];
        wb_addr = k[3:0];
        wb_data = 32'(32'h1000 + 32'h11 * k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cap_en = 1'b0; stage_pc = '0; wb_we = 1'b0; wb_addr = '0;
        wb_data = '0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; trig_stage = '0;
        force_trig = 1'b0; post_cnt = '0; rd_en = 1'b0; rd_idx = '0;
        step();
        step();
        check("rst_state",      256'(state),      256'(0));
        check("rst_done",       256'(done),       256'(0));
        check("rst_count",      256'(count),      256'(0));
        check("rst_wrapped",    256'(wrapped),    256'(0));
        check("rst_rd_valid",   256'(rd_valid),   256'(0));
        check("rst_trig_cycle", 256'(trig_cycle), 256'(0));
        reset = 1'b0;

        // Basic forced trigger, post_cnt=0
        arm = 1'b1; step(); arm = 1'b0;
        check("basic_armed", 256'(state), 256'(1));
        for (int k = 0; k < 5; k++) begin
            cap_en = 1'b1; stage_pc = '0; stage_pc[31:0] = 32'(4 * k);
            wb_we = 1'b1; wb_addr = k[3:0]; wb_data = 32'(32'hA0 + k);
            force_trig = (k == 4);
            stamp[k] = cyc_m[15:0];
            step();
        end
        cap_en = 1'b0; force_trig = 1'b0;
        check("basic_done",  256'(done),       256'(1));
        check("basic_count", 256'(count),      256'(5));
        check("basic_tcyc",  256'(trig_cycle), 256'(stamp[4]));
        cap_en = 1'b1; step(); step(); cap_en = 1'b0;
        check("basic_frozen", 256'(count), 256'(5));
        read_idx(4'd0);
        check("basic_rd0_valid", 256'(rd_valid),               256'(1));
        check("basic_rd0_pc",    256'(rd_data[PC0_LSB +: 32]), 256'(0));
        check("basic_rd0_wb",    256'(rd_data[36:0]),          256'({1'b1, 4'h0, 32'hA0}));
        read_idx(4'd4);
        check("basic_rd4_pc",    256'(rd_data[PC0_LSB +: 32]), 256'(32'h10));
        read_idx(4'd7);
        check("basic_rd7_valid", 256'(rd_valid), 256'(1));
        check("basic_rd7_zero",  256'(rd_data),  256'(0));
        step();
        check("basic_rd_idle", 256'(rd_valid), 256'(0));

        // Wrap: 20 captures, PC match on FETCH at k=19
        trig_en = 1'b1; trig_stage = 3'd0; trig_pc = 32'h4C; post_cnt = 4'd0;
        arm = 1'b1; step(); arm = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cap_en = 1'b1; stage_pc = '0; stage_pc[31:0] = 32'(4 * k);
            drive_wb(k);
            stamp[k] = cyc_m[15:0];
            step();
        end
        cap_en = 1'b0;
        check("wrap_count",   256'(count),      256'(16));
        check("wrap_wrapped", 256'(wrapped),    256'(1));
        check("wrap_done",    256'(done),       256'(1));
        check("wrap_tcyc",    256'(trig_cycle), 256'(stamp[19]));
        read_idx(4'd0);
        check("wrap_rd0_pc",  256'(rd_data[PC0_LSB +: 32]), 256'(32'h10));
        read_idx(4'd15);
        check("wrap_rd15_pc",  256'(rd_data[PC0_LSB +: 32]), 256'(32'h4C));
        check("wrap_rd15_cyc", 256'(rd_data[CYC_LSB +: 16]), 256'(stamp[19]));

        // Re-arm from DONE with a hit and capture request in the arm cycle
        stage_pc = '0; stage_pc[31:0] = 32'h4C; cap_en = 1'b1; force_trig = 1'b1;
        arm = 1'b1; step(); arm = 1'b0; cap_en = 1'b0; force_trig = 1'b0;
        check("rearm_state",   256'(state),      256'(1));
        check("rearm_done",    256'(done),       256'(0));
        check("rearm_count",   256'(count),      256'(0));
        check("rearm_wrapped", 256'(wrapped),    256'(0));
        check("rearm_tcyc",    256'(trig_cycle), 256'(stamp[19]));

        // Post-trigger with stalls: EX/MA PC 0x20 at k=4, post_cnt=3
        trig_en = 1'b1; trig_stage = 3'd3; trig_pc = 32'h20; post_cnt = 4'd3;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) begin
                cap_en = 1'b0; wb_we = 1'b1; wb_addr = 4'hF; wb_data = 32'hDEAD;
                step(); step();
                check("post_stall_state", 256'(state), 256'(2));
                check("post_stall_count", 256'(count), 256'(6));
            end
            cap_en = 1'b1; stage_pc = '0;
            stage_pc[31:0]   = 32'(32'h100 + k);
            stage_pc[96 +: 32] = 32'(8 * k);
            drive_wb(k);
            force_trig = (k == 5);
            stamp[k] = cyc_m[15:0];
            step();
            if (k == 4) check("post_entered", 256'(state), 256'(2));
            if (k == 5) check("post_hit_ignored", 256'(trig_cycle), 256'(stamp[4]));
        end
        cap_en = 1'b0; force_trig = 1'b0;
        check("post_done",  256'(state), 256'(3));
        check("post_count", 256'(count), 256'(8));
        read_idx(4'd4);
        check("post_rd4_pc3", 256'(rd_data[PC3_LSB +: 32]), 256'(32'h20));
        check("post_rd4_cyc", 256'(rd_data[CYC_LSB +: 16]), 256'(stamp[4]));
        read_idx(4'd5);
        check("post_rd5_cyc", 256'(rd_data[CYC_LSB +: 16]), 256'(stamp[5]));
        cyc5_obs = rd_data[CYC_LSB +: 16];
        read_idx(4'd6);
        check("post_stall_gap", 256'(16'(rd_data[CYC_LSB +: 16] - cyc5_obs)), 256'(3));
        check("post_rd6_wb",    256'(rd_data[36:0]), 256'({1'b0, 4'h6, 32'h1066}));
        read_idx(4'd7);
        check("post_rd7_pc0",   256'(rd_data[PC0_LSB +: 32]), 256'(32'h107));
        check("post_rd7_wb",    256'(rd_data[36:0]), 256'({1'b1, 4'h7, 32'h1077}));
        read_idx(4'd8);
        check("post_rd8_zero",  256'(rd_data), 256'(0));

        // Reset while in POST with two entries still to go
        trig_en = 1'b0; post_cnt = 4'd3;
        arm = 1'b1; step(); arm = 1'b0;
        cap_en = 1'b1; force_trig = 1'b1; step(); force_trig = 1'b0;
        step();
        check("midrst_pre_state", 256'(state), 256'(2));
        cap_en = 1'b0; reset = 1'b1; rd_en = 1'b1; rd_idx = 4'd0;
        step();
        reset = 1'b0; rd_en = 1'b0;
        check("midrst_state",    256'(state),    256'(0));
        check("midrst_count",    256'(count),    256'(0));
        check("midrst_rd_drop",  256'(rd_valid), 256'(0));
        read_idx(4'd0);
        check("midrst_rd_valid", 256'(rd_valid), 256'(1));
        check("midrst_rd_zero",  256'(rd_data),  256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
